// File: rtl/memory_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-port memory with fixed latency.
// Optional: define ARB_ROUND_ROBIN_EN for round-robin contention instead of data-first priority.
module memory_port_arbiter #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic [15:0] if_rdata,
  output logic        if_ready,
  input  logic        dm_rd,
  input  logic        dm_wr,
  input  logic [15:0] dm_addr,
  input  logic [15:0] dm_wdata,
  output logic [15:0] dm_rdata,
  output logic        dm_ready,
  output logic        mem_en,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        stall
);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       if_elig, dm_elig, prefer_if, grant_dm, grant_if;

  // A port is not re-granted in the cycle its ready pulse is showing.
  assign if_elig  = if_req & ~if_ready;
  assign dm_elig  = (dm_rd | dm_wr) & ~dm_ready;
  assign grant_dm = dm_elig & (~if_elig | ~prefer_if);
  assign grant_if = if_elig & ~grant_dm;

  assign stall = (if_req & ~if_ready) | ((dm_rd | dm_wr) & ~dm_ready);

`ifdef ARB_ROUND_ROBIN_EN
  logic last_dm;  // set when the data port won the latest grant, so fetch is favoured next

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      last_dm <= 1'b0;
    else if (state == IDLE && (grant_dm || grant_if))
      last_dm <= grant_dm;
  end

  assign prefer_if = last_dm;
`else
  assign prefer_if = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_ready  <= 1'b0;
      dm_ready  <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      if_ready <= 1'b0;
      dm_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_dm) begin
            state     <= BUSY_DM;
            cnt       <= CNT_INIT;
            mem_en    <= 1'b1;
            mem_we    <= dm_wr;  // rd+wr together counts as a write
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
          end else if (grant_if) begin
            state     <= BUSY_IF;
            cnt       <= CNT_INIT;
            mem_en    <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
          end
        end
        BUSY_IF, BUSY_DM: begin
          if (cnt == 4'd0) begin
            state     <= IDLE;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if (state == BUSY_IF) begin
              if_rdata <= mem_rdata;
              if_ready <= 1'b1;
            end else begin
              if (!mem_we) dm_rdata <= mem_rdata;
              dm_ready <= 1'b1;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Bench for memory_port_arbiter: MEM_LAT=1 and MEM_LAT=3 instances on shared inputs,
// directed scenarios plus random traffic against a transaction-level reference model.
module tb_memory_port_arbiter;

  localparam int W = 69;

  logic        clk, rst;
  logic        if_req, dm_rd, dm_wr;
  logic [15:0] if_addr, dm_addr, dm_wdata, mem_rdata;

  logic [15:0] a_if_rdata, a_dm_rdata, a_mem_addr, a_mem_wdata;
  logic        a_if_ready, a_dm_ready, a_mem_en, a_mem_we, a_stall;
  logic [15:0] b_if_rdata, b_dm_rdata, b_mem_addr, b_mem_wdata;
  logic        b_if_ready, b_dm_ready, b_mem_en, b_mem_we, b_stall;

  memory_port_arbiter #(.MEM_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_rdata(a_if_rdata),
    .if_ready(a_if_ready), .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(a_dm_rdata), .dm_ready(a_dm_ready), .mem_en(a_mem_en),
    .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(mem_rdata), .stall(a_stall));

  memory_port_arbiter #(.MEM_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_rdata(b_if_rdata),
    .if_ready(b_if_ready), .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(b_dm_rdata), .dm_ready(b_dm_ready), .mem_en(b_mem_en),
    .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(mem_rdata), .stall(b_stall));

  logic [W-1:0] obs [2];
  assign obs[0] = {a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata, a_if_ready, a_if_rdata,
                   a_dm_ready, a_dm_rdata, a_stall};
  assign obs[1] = {b_mem_en, b_mem_we, b_mem_addr, b_mem_wdata, b_if_ready, b_if_rdata,
                   b_dm_ready, b_dm_rdata, b_stall};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference model: one in-flight transaction per instance, described by who owns the
  // memory and the edge number at which it finishes.
  localparam int NONE = 0, P_IF = 1, P_DM = 2;
  int          lat      [2] = '{1, 3};
  int          owner    [2];
  int          done_at  [2];
  logic [15:0] t_addr   [2];
  logic [15:0] t_wdata  [2];
  logic        t_we     [2];
  logic [15:0] m_if_rd  [2];
  logic [15:0] m_dm_rd  [2];
  logic        m_if_rdy [2];
  logic        m_dm_rdy [2];
  logic        last_dm  [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      owner[k] = NONE; done_at[k] = 0; t_addr[k] = '0; t_wdata[k] = '0; t_we[k] = 1'b0;
      m_if_rd[k] = '0; m_dm_rd[k] = '0; m_if_rdy[k] = 1'b0; m_dm_rdy[k] = 1'b0;
      last_dm[k] = 1'b0;
    end
  endtask

  function automatic logic [W-1:0] expv(int k);
    logic busy, st;
    busy = (owner[k] != NONE);
    st   = (if_req & ~m_if_rdy[k]) | ((dm_rd | dm_wr) & ~m_dm_rdy[k]);
    return {busy, busy & t_we[k], busy ? t_addr[k] : 16'h0, busy ? t_wdata[k] : 16'h0,
            m_if_rdy[k], m_if_rd[k], m_dm_rdy[k], m_dm_rd[k], st};
  endfunction

  task automatic model_edge(int k);
    bit want_if, want_dm, pick_dm, prefer_if;
    logic nr_if, nr_dm;
    want_if = if_req && !m_if_rdy[k];
    want_dm = (dm_rd || dm_wr) && !m_dm_rdy[k];
    nr_if = 1'b0;
    nr_dm = 1'b0;
    if (owner[k] != NONE) begin
      if (cyc == done_at[k]) begin
        if (owner[k] == P_IF) begin
          m_if_rd[k] = mem_rdata; nr_if = 1'b1;
        end else begin
          if (!t_we[k]) m_dm_rd[k] = mem_rdata;
          nr_dm = 1'b1;
        end
        owner[k] = NONE;
      end
    end else if (want_if || want_dm) begin
`ifdef ARB_ROUND_ROBIN_EN
      prefer_if = last_dm[k];
`else
      prefer_if = 1'b0;
`endif
      pick_dm = want_dm && !(want_if && prefer_if);
      last_dm[k] = pick_dm;
      owner[k]   = pick_dm ? P_DM : P_IF;
      done_at[k] = cyc + lat[k];
      t_addr[k]  = pick_dm ? dm_addr : if_addr;
      t_wdata[k] = pick_dm ? dm_wdata : 16'h0;
      t_we[k]    = pick_dm && dm_wr;
    end
    m_if_rdy[k] = nr_if;
    m_dm_rdy[k] = nr_dm;
  endtask

  task automatic chk(string tag, logic [W-1:0] o, logic [W-1:0] e);
    n_checks++;
    assert (o === e) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, o, e);
  endtask

  // Inputs are set at the falling edge; step checks both instances, then crosses one rising edge.
  task automatic step();
    if (rst) model_reset();
    #1;
    for (int k = 0; k < 2; k++)
      chk($sformatf("model_c%0d_lat%0d", cyc, lat[k]), obs[k], expv(k));
    @(posedge clk);
    cyc++;
    if (rst) model_reset();
    else for (int k = 0; k < 2; k++) model_edge(k);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    if_req = 0; dm_rd = 0; dm_wr = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int pulses;
    rst = 1'b1; idle_inputs();
    if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
    model_reset();
    @(negedge clk);
    step();
    chk("reset_state_lat1", obs[0], '0);
    chk("reset_state_lat3", obs[1], '0);
    rst = 1'b0;
    step();

    // Single fetch, MEM_LAT=1
    if_req = 1; if_addr = 16'h0010; mem_rdata = 16'hA5A5;
    step();
    if_req = 0;
    chk("fetch_mem_en", W'(a_mem_en), W'(1));
    chk("fetch_mem_addr", W'(a_mem_addr), W'(16'h0010));
    step();
    chk("fetch_ready", W'(a_if_ready), W'(1));
    chk("fetch_rdata", W'(a_if_rdata), W'(16'hA5A5));
    step(); step(); step();

    // Single store, MEM_LAT=3
    dm_wr = 1; dm_addr = 16'h0200; dm_wdata = 16'h1234; mem_rdata = 16'hBEEF;
    step();
    dm_wr = 0;
    chk("store_we_c1", W'({b_mem_we, b_mem_addr, b_mem_wdata}), W'({1'b1, 16'h0200, 16'h1234}));
    step();
    chk("store_we_c2", W'(b_mem_we), W'(1));
    step();
    chk("store_we_c3", W'(b_mem_we), W'(1));
    step();
    chk("store_ready", W'(b_dm_ready), W'(1));
    chk("store_rdata_kept", W'(b_dm_rdata), W'(0));
    step();

    // Reset during the second busy cycle of a MEM_LAT=3 read
    dm_rd = 1; dm_addr = 16'h0300; mem_rdata = 16'h5555;
    step();
    dm_rd = 0;
    step();
    rst = 1'b1;
    #1;
    chk("midreset_outputs_zero", W'(obs[1][W-1:1]), '0);
    #1;
    step();
    rst = 1'b0;

    // Held fetch right after reset: MEM_LAT=3 normal latency, MEM_LAT=1 one fetch every 3 cycles
    if_req = 1; if_addr = 16'h0042; mem_rdata = 16'h7777;
    pulses = 0;
    for (int i = 1; i <= 9; i++) begin
      step();
      pulses += int'(a_if_ready);
      if (i == 4) chk("post_reset_lat3_ready", W'(b_if_ready), W'(1));
    end
    chk("held_fetch_pulses", W'(pulses), W'(3));
    idle_inputs();
    repeat (4) step();

    // Same-cycle contention from the reset priority: data first, fetch immediately after
    do_reset();
    if_req = 1; if_addr = 16'h0111; dm_rd = 1; dm_addr = 16'h0222; mem_rdata = 16'h3C3C;
    step();
    dm_rd = 0;
    chk("contend_dm_first_lat1", W'(a_mem_addr), W'(16'h0222));
    chk("contend_dm_first_lat3", W'(b_mem_addr), W'(16'h0222));
    step();
    chk("contend_stall_wait", W'({a_dm_ready, a_stall}), W'(2'b11));
    step();
    chk("contend_if_next", W'(a_mem_addr), W'(16'h0111));
    step();
    chk("contend_stall_clear", W'({a_if_ready, a_stall}), W'(2'b10));
    if_req = 0;
    repeat (4) step();

    // Random traffic with occasional asynchronous resets
    for (int i = 0; i < 600; i++) begin
      if_req    = ($urandom_range(0, 99) < 55);
      dm_rd     = ($urandom_range(0, 99) < 35);
      dm_wr     = ($urandom_range(0, 99) < 25);
      if_addr   = 16'($urandom);
      dm_addr   = 16'($urandom);
      dm_wdata  = 16'($urandom);
      mem_rdata = 16'($urandom);
      rst       = ($urandom_range(0, 79) == 0);
      step();
    end
    rst = 1'b0; idle_inputs();
    repeat (5) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
